// File: rtl/mem_1r1w_masked_banked_if.sv
// Read/write port bundle for mem_1r1w_masked_banked.
// slave: memory side (drives init_done, R0_data, R0_valid); master: requester side.
interface mem_1r1w_masked_banked_if #(
    parameter int ADDR_W = 5,
    parameter int WIDTH  = 64,
    parameter int MASK_W = 8
);
    logic              init_done;
    logic [ADDR_W-1:0] R0_addr;
    logic              R0_en;
    logic [WIDTH-1:0]  R0_data;
    logic              R0_valid;
    logic [ADDR_W-1:0] W0_addr;
    logic              W0_en;
    logic [WIDTH-1:0]  W0_data;
    logic [MASK_W-1:0] W0_mask;

    modport master (
        input  init_done, R0_data, R0_valid,
        output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask
    );

    modport slave (
        output init_done, R0_data, R0_valid,
        input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask
    );
endinterface

// File: rtl/mem_1r1w_masked_banked.sv
// Banked 1R1W memory with lane write mask, post-reset clear sweep, 1-cycle read.
// Ports: clk, reset (sync, active-high), bus (slave modport: init_done, R0_*, W0_*).
// Optional macro MEM_1R1W_BYPASS_EN: same-address read returns write-merged word.
module mem_1r1w_masked_banked #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 64,
    parameter int MASK_GRAN  = 8,
    parameter int BANK_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_1r1w_masked_banked_if.slave  bus
);
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MASK_W    = WIDTH / MASK_GRAN;
    localparam int ROW_BITS  = $clog2(BANK_DEPTH);
    localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int NUM_BANKS = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_q;
    logic [ROW_W-1:0] cnt_q;
    logic             init_done;

    assign init_done     = (state_q == ST_READY);
    assign bus.init_done = init_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ROW_W'(1);
                    if (cnt_q == ROW_W'(BANK_DEPTH - 1))
                        state_q <= ST_READY;
                end
                ST_READY: ;
                default:  state_q <= ST_INIT;
            endcase
        end
    end

    // Address decode; the row mask keeps BANK_DEPTH==1 at row 0.
    logic              rd_in, wr_in, rd_acc, wr_acc;
    logic [ADDR_W-1:0] rd_bank, wr_bank;
    logic [ROW_W-1:0]  rd_row, wr_row;

    assign rd_in   = 32'(bus.R0_addr) < 32'(DEPTH);
    assign wr_in   = 32'(bus.W0_addr) < 32'(DEPTH);
    assign rd_bank = bus.R0_addr >> ROW_BITS;
    assign wr_bank = bus.W0_addr >> ROW_BITS;
    assign rd_row  = ROW_W'(bus.R0_addr) & ROW_W'(BANK_DEPTH - 1);
    assign wr_row  = ROW_W'(bus.W0_addr) & ROW_W'(BANK_DEPTH - 1);
    assign rd_acc  = bus.R0_en && init_done;
    assign wr_acc  = bus.W0_en && init_done && wr_in;

    logic [WIDTH-1:0] bank_rd [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic [ADDR_W-1:0] BANK_ID = ADDR_W'(b);

        logic [WIDTH-1:0] ram [BANK_DEPTH];
        logic [WIDTH-1:0] rd_word;
        logic [WIDTH-1:0] rd_q;
        logic             rd_en, wr_en;

        assign rd_en = rd_acc && rd_in && (rd_bank == BANK_ID);
        assign wr_en = wr_acc && (wr_bank == BANK_ID);

`ifdef MEM_1R1W_BYPASS_EN
        // Same-row collision: forward the masked lanes of the write.
        always_comb begin
            rd_word = ram[rd_row];
            if (wr_en && (wr_row == rd_row)) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (bus.W0_mask[l])
                        rd_word[l*MASK_GRAN +: MASK_GRAN] =
                            bus.W0_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
`else
        assign rd_word = ram[rd_row];
`endif

        always_ff @(posedge clk) begin
            if (!init_done) begin
                ram[cnt_q] <= '0;
            end else if (wr_en) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (bus.W0_mask[l])
                        ram[wr_row][l*MASK_GRAN +: MASK_GRAN] <=
                            bus.W0_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset)
                rd_q <= '0;
            else if (rd_en)
                rd_q <= rd_word;
        end

        assign bank_rd[b] = rd_q;
    end

    // Bank select travels with the read so the output mux picks the right bank.
    logic              valid_q;
    logic              oor_q;
    logic [BANK_W-1:0] sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            oor_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
                oor_q <= !rd_in;
                sel_q <= BANK_W'(rd_bank);
            end
        end
    end

    always_comb begin
        bus.R0_data = '0;
        if (!oor_q) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (sel_q == BANK_W'(b))
                    bus.R0_data = bank_rd[b];
            end
        end
    end

    assign bus.R0_valid = valid_q;
endmodule

// File: tb/tb_mem_1r1w_masked_banked.sv
// Directed bench for mem_1r1w_masked_banked (48x64, 8-bit lanes, 16-row banks).
// Tasks per scenario, each comparing against hand-computed values.
module tb_mem_1r1w_masked_banked;
    localparam int DEPTH      = 48;
    localparam int WIDTH      = 64;
    localparam int MASK_GRAN  = 8;
    localparam int BANK_DEPTH = 16;
    localparam int ADDR_W     = 6;
    localparam int MASK_W     = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_1r1w_masked_banked_if #(
        .ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_W(MASK_W)
    ) bus ();

    mem_1r1w_masked_banked #(
        .DEPTH(DEPTH), .WIDTH(WIDTH),
        .MASK_GRAN(MASK_GRAN), .BANK_DEPTH(BANK_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.R0_en   = 1'b0;
        bus.W0_en   = 1'b0;
        bus.R0_addr = '0;
        bus.W0_addr = '0;
        bus.W0_data = '0;
        bus.W0_mask = '0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        bus.R0_en   = 1'b1;
        bus.R0_addr = a;
        step();
        bus.R0_en   = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [63:0] d,
                      input logic [7:0] m);
        bus.W0_en   = 1'b1;
        bus.W0_addr = a;
        bus.W0_data = d;
        bus.W0_mask = m;
        step();
        bus.W0_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_done;
        idle();
        reset = 1'b1;
        step();
        step();
        total++;
        if (bus.init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init_done: got %b want 0", bus.init_done);
        end
        total++;
        if (bus.R0_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", bus.R0_valid);
        end
        total++;
        if (bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", bus.R0_data);
        end
        reset       = 1'b0;
        bus.R0_en   = 1'b1;
        bus.R0_addr = 6'd47;
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) bus.R0_en = 1'b0;
            step();
            exp_done = (i == 16);
            total++;
            if (bus.init_done !== exp_done) begin
                bad++;
                $display("FAIL sweep_done[%0d]: got %b want %b",
                         i, bus.init_done, exp_done);
            end
            total++;
            if (bus.R0_valid !== 1'b0) begin
                bad++;
                $display("FAIL sweep_valid[%0d]: got %b want 0",
                         i, bus.R0_valid);
            end
        end
    endtask

    task automatic test_init_read();
        rd(6'd47);
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL read47: got v=%b d=%h want v=1 d=0",
                     bus.R0_valid, bus.R0_data);
        end
        step();
        total++;
        if (bus.R0_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid: got %b want 0", bus.R0_valid);
        end
    endtask

    task automatic test_write_read();
        wr(6'd20, 64'h1122334455667788, 8'hFF);
        rd(6'd20);
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h1122334455667788) begin
            bad++;
            $display("FAIL read20: got v=%b d=%h want v=1 d=1122334455667788",
                     bus.R0_valid, bus.R0_data);
        end
        step();
        total++;
        if (bus.R0_valid !== 1'b0 || bus.R0_data !== 64'h1122334455667788) begin
            bad++;
            $display("FAIL hold: got v=%b d=%h want v=0 d=1122334455667788",
                     bus.R0_valid, bus.R0_data);
        end
        rd(6'd4);
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL read4: got v=%b d=%h want v=1 d=0",
                     bus.R0_valid, bus.R0_data);
        end
    endtask

    task automatic test_mask();
        wr(6'd20, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(6'd20);
        total++;
        if (bus.R0_data !== 64'h11223344AAAAAAAA) begin
            bad++;
            $display("FAIL mask_lo: got %h want 11223344aaaaaaaa", bus.R0_data);
        end
        wr(6'd36, 64'hDEADBEEFDEADBEEF, 8'h00);
        rd(6'd36);
        total++;
        if (bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL mask_zero: got %h want 0", bus.R0_data);
        end
    endtask

    task automatic test_collision();
        logic [63:0] exp;
`ifdef MEM_1R1W_BYPASS_EN
        exp = 64'hFFFFFFFFAAAAAAAA;
`else
        exp = 64'h11223344AAAAAAAA;
`endif
        bus.R0_en   = 1'b1;
        bus.R0_addr = 6'd20;
        bus.W0_en   = 1'b1;
        bus.W0_addr = 6'd20;
        bus.W0_data = 64'hFFFFFFFFFFFFFFFF;
        bus.W0_mask = 8'hF0;
        step();
        idle();
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== exp) begin
            bad++;
            $display("FAIL collide: got v=%b d=%h want v=1 d=%h",
                     bus.R0_valid, bus.R0_data, exp);
        end
        rd(6'd20);
        total++;
        if (bus.R0_data !== 64'hFFFFFFFFAAAAAAAA) begin
            bad++;
            $display("FAIL after_collide: got %h want ffffffffaaaaaaaa",
                     bus.R0_data);
        end
    endtask

    task automatic test_back_to_back();
        // read 20 while writing 21 (same bank, other row), then read 21, then 4
        bus.R0_en   = 1'b1;
        bus.R0_addr = 6'd20;
        bus.W0_en   = 1'b1;
        bus.W0_addr = 6'd21;
        bus.W0_data = 64'h0123456789ABCDEF;
        bus.W0_mask = 8'hFF;
        step();
        bus.W0_en   = 1'b0;
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'hFFFFFFFFAAAAAAAA) begin
            bad++;
            $display("FAIL b2b_20: got v=%b d=%h want v=1 d=ffffffffaaaaaaaa",
                     bus.R0_valid, bus.R0_data);
        end
        bus.R0_addr = 6'd21;
        step();
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0123456789ABCDEF) begin
            bad++;
            $display("FAIL b2b_21: got v=%b d=%h want v=1 d=0123456789abcdef",
                     bus.R0_valid, bus.R0_data);
        end
        bus.R0_addr = 6'd4;
        step();
        bus.R0_en   = 1'b0;
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL b2b_4: got v=%b d=%h want v=1 d=0",
                     bus.R0_valid, bus.R0_data);
        end
    endtask

    task automatic test_out_of_range();
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 6'd2;
        addrs[1] = 6'd18;
        addrs[2] = 6'd34;
        wr(6'd50, 64'h5, 8'hFF);
        rd(6'd50);
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL read50: got v=%b d=%h want v=1 d=0",
                     bus.R0_valid, bus.R0_data);
        end
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i]);
            total++;
            if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
                bad++;
                $display("FAIL alias%0d: got v=%b d=%h want v=1 d=0",
                         addrs[i], bus.R0_valid, bus.R0_data);
            end
        end
    endtask

    task automatic test_reset_after_use();
        logic exp_done;
        bus.R0_en   = 1'b1;
        bus.R0_addr = 6'd20;
        step();
        bus.R0_en = 1'b0;
        reset     = 1'b1;
        step();
        total++;
        if (bus.R0_valid !== 1'b0 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL rst_valid: got v=%b d=%h want v=0 d=0",
                     bus.R0_valid, bus.R0_data);
        end
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_done = (i == 16);
            total++;
            if (bus.init_done !== exp_done) begin
                bad++;
                $display("FAIL resweep_done[%0d]: got %b want %b",
                         i, bus.init_done, exp_done);
            end
        end
        rd(6'd20);
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL rst_read20: got v=%b d=%h want v=1 d=0",
                     bus.R0_valid, bus.R0_data);
        end
        rd(6'd21);
        total++;
        if (bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL rst_read21: got %h want 0", bus.R0_data);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic exp_done;
        wr(6'd20, 64'hCAFEF00DCAFEF00D, 8'hFF);
        wr(6'd45, 64'h1234, 8'hFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        total++;
        if (bus.init_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_done: got %b want 0", bus.init_done);
        end
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_done = (i == 16);
            total++;
            if (bus.init_done !== exp_done) begin
                bad++;
                $display("FAIL mid_sweep_done[%0d]: got %b want %b",
                         i, bus.init_done, exp_done);
            end
        end
        rd(6'd20);
        total++;
        if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL mid_read20: got v=%b d=%h want v=1 d=0",
                     bus.R0_valid, bus.R0_data);
        end
        rd(6'd45);
        total++;
        if (bus.R0_data !== 64'h0) begin
            bad++;
            $display("FAIL mid_read45: got %h want 0", bus.R0_data);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_init_read();
        test_write_read();
        test_mask();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_after_use();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
